// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its command FIFO.
package alu_pkg;

   localparam int OPW  = 4;
   localparam int RESW = 8;

   localparam logic [2:0] ADD  = 3'b000;
   localparam logic [2:0] SUB  = 3'b001;
   localparam logic [2:0] MUL  = 3'b010;
   localparam logic [2:0] AND  = 3'b011;
   localparam logic [2:0] OR   = 3'b100;
   localparam logic [2:0] NOT  = 3'b101;
   localparam logic [2:0] XOR  = 3'b110;
   localparam logic [2:0] XNOR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef struct packed {
      logic [OPW-1:0] opa;
      logic [OPW-1:0] opb;
      logic [2:0]     opcode;
      logic           chain;
   } alu_cmd_t;

   localparam int CMDW = $bits(alu_cmd_t);

   // Zero flag of a captured result.
   function automatic logic res_is_zero(input logic [RESW-1:0] v);
      return (v == 8'h00);
   endfunction

   // High-nibble flag: carry, borrow or upper product bits present.
   function automatic logic res_has_hi(input logic [RESW-1:0] v);
      return |v[RESW-1:OPW];
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; head is presented on rdata while non-empty.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CMDW
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic          do_push_s;
   logic          do_pop_s;

   assign full      = (count_r == DEPTH_CNT);
   assign empty     = (count_r == {(AW+1){1'b0}});
   assign count     = count_r;
   assign rdata     = mem_r[rptr_r];
   assign do_push_s = push && !full;
   assign do_pop_s  = pop && !empty;

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates reads.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the combinational ALU: buffers commands, issues one
// at a time through registered operands, captures the result with flags.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic [3:0]             cmd_opA,
   input  logic [3:0]             cmd_opB,
   input  logic [2:0]             cmd_opcode,
   input  logic                   cmd_chain,
   output logic [3:0]             alu_opA,
   output logic [3:0]             alu_opB,
   output logic [2:0]             alu_opcode,
   input  logic [7:0]             alu_result,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [7:0]             res_data,
   output logic [2:0]             res_opcode,
   output logic                   res_zero,
   output logic                   res_hi,
   output logic [$clog2(DEPTH):0] fifo_count
);

   state_t          state_r;
   state_t          state_nxt_s;
   logic            push_s;
   logic            pop_s;
   logic            capture_s;
   logic            fifo_full_s;
   logic            fifo_empty_s;
   alu_cmd_t        wcmd_s;
   alu_cmd_t        head_s;
   logic [CMDW-1:0] head_bits_s;

   logic [OPW-1:0]  alu_opa_r;
   logic [OPW-1:0]  alu_opb_r;
   logic [2:0]      alu_opcode_r;
   logic [RESW-1:0] res_data_r;
   logic [2:0]      res_opcode_r;
   logic            res_zero_r;
   logic            res_hi_r;
   logic [RESW-1:0] last_result_r;

   assign wcmd_s    = '{opa: cmd_opA, opb: cmd_opB, opcode: cmd_opcode, chain: cmd_chain};
   assign head_s    = alu_cmd_t'(head_bits_s);
   // Full is a decode of the registered count, so a same-cycle pop never opens the door.
   assign cmd_ready = !fifo_full_s;
   assign push_s    = cmd_valid && cmd_ready;
   assign res_valid = (state_r == DONE);

   alu_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMDW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .wdata (wcmd_s),
      .rdata (head_bits_s),
      .count (fifo_count),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Next-state and pop/capture decode for the IDLE/EXEC/DONE sequencer.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      capture_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!fifo_empty_s) begin
               state_nxt_s = EXEC;
               pop_s       = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         EXEC: begin
            state_nxt_s = DONE;
            capture_s   = 1'b1;
         end
         DONE: begin
            if (res_ready) begin
               if (!fifo_empty_s) begin
                  state_nxt_s = EXEC;
                  pop_s       = 1'b1;
               end else begin
                  state_nxt_s = IDLE;
               end
            end else begin
               state_nxt_s = DONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Operand registers feeding the ALU; chained commands take A from the last result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_opa_r    <= 4'h0;
         alu_opb_r    <= 4'h0;
         alu_opcode_r <= 3'b000;
      end else if (pop_s) begin
         alu_opa_r    <= head_s.chain ? last_result_r[OPW-1:0] : head_s.opa;
         alu_opb_r    <= head_s.opb;
         alu_opcode_r <= head_s.opcode;
      end
   end

   // Result capture at the end of EXEC, with flags registered alongside the data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_data_r    <= 8'h00;
         res_opcode_r  <= 3'b000;
         res_zero_r    <= 1'b1;
         res_hi_r      <= 1'b0;
         last_result_r <= 8'h00;
      end else if (capture_s) begin
         res_data_r    <= alu_result;
         res_opcode_r  <= alu_opcode_r;
         res_zero_r    <= res_is_zero(alu_result);
         res_hi_r      <= res_has_hi(alu_result);
         last_result_r <= alu_result;
      end
   end

   assign alu_opA    = alu_opa_r;
   assign alu_opB    = alu_opb_r;
   assign alu_opcode = alu_opcode_r;
   assign res_data   = res_data_r;
   assign res_opcode = res_opcode_r;
   assign res_zero   = res_zero_r;
   assign res_hi     = res_hi_r;

endmodule
